// File: rtl/reg_status_file.sv
// reg_status_file: architectural register value/dependency table with
// 2 issue slots, 2 commit lanes and 4 combinational read ports.
// Optional macro RSF_COMMIT_BYPASS_EN forwards same-cycle commit results
// onto read ports whose stored producer tag matches a committing tag.
module reg_status_file #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_NUM   = 32,
  parameter int unsigned ROB_IDX_W = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             clr_in,
  input  logic [1:0]                       iss_valid,
  input  logic [2*$clog2(REG_NUM)-1:0]     iss_rd,
  input  logic [2*ROB_IDX_W-1:0]           iss_rob,
  input  logic [4*$clog2(REG_NUM)-1:0]     rs_pos,
  output logic [4*DATA_W-1:0]              rs_val,
  output logic [4*ROB_IDX_W-1:0]           rs_depend,
  input  logic [1:0]                       cmt_valid,
  input  logic [2*ROB_IDX_W-1:0]           cmt_rob,
  input  logic [2*$clog2(REG_NUM)-1:0]     cmt_reg,
  input  logic [2*DATA_W-1:0]              cmt_val
);

  localparam int unsigned REG_IDX_W = $clog2(REG_NUM);

  logic [DATA_W-1:0]    val_q [REG_NUM];
  logic [ROB_IDX_W-1:0] dep_q [REG_NUM];

  logic [REG_IDX_W-1:0] iss_rd_a  [2];
  logic [ROB_IDX_W-1:0] iss_rob_a [2];
  logic                 iss_fire  [2];
  logic [REG_IDX_W-1:0] cmt_reg_a [2];
  logic [ROB_IDX_W-1:0] cmt_rob_a [2];
  logic [DATA_W-1:0]    cmt_val_a [2];
  logic                 cmt_fire  [2];

  // Unpack per-slot / per-lane fields; register 0 never fires a write.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      iss_rd_a[i]  = iss_rd[i*REG_IDX_W +: REG_IDX_W];
      iss_rob_a[i] = iss_rob[i*ROB_IDX_W +: ROB_IDX_W];
      iss_fire[i]  = iss_valid[i] && (iss_rd_a[i] != '0);
      cmt_reg_a[i] = cmt_reg[i*REG_IDX_W +: REG_IDX_W];
      cmt_rob_a[i] = cmt_rob[i*ROB_IDX_W +: ROB_IDX_W];
      cmt_val_a[i] = cmt_val[i*DATA_W +: DATA_W];
      cmt_fire[i]  = cmt_valid[i] && (cmt_reg_a[i] != '0);
    end
  end

  // Table update: commits first, then flush or issue so issue tags win.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int r = 0; r < REG_NUM; r++) begin
        val_q[r] <= '0;
        dep_q[r] <= '0;
      end
    end else if (rdy_in) begin
      for (int j = 0; j < 2; j++) begin
        if (cmt_fire[j]) begin
          val_q[cmt_reg_a[j]] <= cmt_val_a[j];
          if (dep_q[cmt_reg_a[j]] == cmt_rob_a[j]) begin
            dep_q[cmt_reg_a[j]] <= '0;
          end
        end
      end
      if (clr_in) begin
        for (int r = 0; r < REG_NUM; r++) begin
          dep_q[r] <= '0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (iss_fire[i]) begin
            dep_q[iss_rd_a[i]] <= iss_rob_a[i];
          end
        end
      end
    end
  end

  logic [REG_IDX_W-1:0] pos_k;
  logic [DATA_W-1:0]    rd_val;
  logic [ROB_IDX_W-1:0] rd_dep;

  // Read ports: table lookup, optional commit forward, intra-group RAW, x0.
  always_comb begin
    rs_val    = '0;
    rs_depend = '0;
    pos_k     = '0;
    rd_val    = '0;
    rd_dep    = '0;
    for (int k = 0; k < 4; k++) begin
      pos_k  = rs_pos[k*REG_IDX_W +: REG_IDX_W];
      rd_val = val_q[pos_k];
      rd_dep = dep_q[pos_k];
`ifdef RSF_COMMIT_BYPASS_EN
      for (int j = 0; j < 2; j++) begin
        if (cmt_fire[j] && (dep_q[pos_k] != '0) && (dep_q[pos_k] == cmt_rob_a[j])) begin
          rd_val = cmt_val_a[j];
          rd_dep = '0;
        end
      end
`endif
      if ((k >= 2) && iss_valid[0] && (iss_rd_a[0] == pos_k) && (pos_k != '0)) begin
        rd_dep = iss_rob_a[0];
      end
      if (pos_k == '0) begin
        rd_val = '0;
        rd_dep = '0;
      end
      rs_val[k*DATA_W +: DATA_W]          = rd_val;
      rs_depend[k*ROB_IDX_W +: ROB_IDX_W] = rd_dep;
    end
  end

endmodule

// File: doc/reg_status_file.md
REG_STATUS_FILE -- requirements
Module: reg_status_file

Interface
REQ-001 Parameter DATA_W, 32, register data width.
REQ-002 Parameter REG_NUM, 32, architectural register count (power of two); REG_IDX_W = log2(REG_NUM).
REQ-003 Parameter ROB_IDX_W, 4, ROB tag width; tag 0 reserved as "no dependency".
REQ-004 clk_in  input  1  clock, all state updates on rising edge.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 rdy_in  input  1  global enable; low = hold all state.
REQ-007 clr_in  input  1  pipeline flush (mispredict).
REQ-008 iss_valid  input  2  per-slot issue strobe; slot 0 older than slot 1.
REQ-009 iss_rd  input  2*REG_IDX_W  per-slot destination register.
REQ-010 iss_rob  input  2*ROB_IDX_W  per-slot ROB tag of issuing instruction.
REQ-011 rs_pos  input  4*REG_IDX_W  read port k = slot k/2, rs1 (k even) / rs2 (k odd).
REQ-012 rs_val  output  4*DATA_W  per-port register value.
REQ-013 rs_depend  output  4*ROB_IDX_W  per-port producer tag, 0 = value ready.
REQ-014 cmt_valid  input  2  per-lane commit strobe; lane 0 older than lane 1.
REQ-015 cmt_rob  input  2*ROB_IDX_W  per-lane committing ROB tag.
REQ-016 cmt_reg  input  2*REG_IDX_W  per-lane destination register.
REQ-017 cmt_val  input  2*DATA_W  per-lane result value.

Function
REQ-018 State: val[REG_NUM] (DATA_W), dep[REG_NUM] (ROB_IDX_W); x0 val and dep permanently 0.
REQ-019 Read ports combinational, zero latency: rs_val = val[pos], rs_depend = dep[pos], subject to REQ-020..022.
REQ-020 Port with pos 0: val 0, depend 0 always.
REQ-021 Slot-1 ports: if iss_valid[0] and iss_rd[0] == pos != 0, depend = iss_rob[0] (intra-group RAW), val don't-care.
REQ-022 Commit bypass per REQ-036 applies before REQ-021; REQ-021 has priority.
REQ-023 Commit lane j (cmt_valid[j], cmt_reg[j] != 0): val[reg] <= cmt_val[j]; dep[reg] <= 0 only if dep[reg] == cmt_rob[j].
REQ-024 Both lanes commit same reg: lane 1 value wins; dep cleared if either tag matches current dep.
REQ-025 Issue slot i (iss_valid[i], iss_rd[i] != 0): dep[rd] <= iss_rob[i].
REQ-026 Both slots issue same rd: slot 1 tag wins.
REQ-027 Issue and commit same reg same cycle: issue tag wins over dep clear; value still written.
REQ-028 clr_in high (rdy_in high): all dep <= 0; commits that cycle still write val; issues ignored.
REQ-029 rdy_in low: no state change; reads remain combinational on held state.
REQ-030 Priority: rst_in > !rdy_in > clr_in > commit/issue.

Reset
REQ-031 rst_in high at rising edge: all val and dep <= 0, overrides rdy_in and clr_in.
REQ-032 After reset every port returns rs_val 0, rs_depend 0; reset mid-operation discards pending issue/commit that cycle.

Configuration
REQ-033 Macro RSF_COMMIT_BYPASS_EN selects same-cycle commit forwarding on read ports.
REQ-034 Defined: port whose dep[pos] equals a valid cmt_rob[j] (reg != 0) returns cmt_val[j], depend 0; lane 1 preferred on double match.
REQ-035 Undefined: ports return stored table only; committed value visible next cycle.
REQ-036 Bypass condition is tag match only, independent of cmt_reg.

Verification
REQ-037 Reset, read all ports pos 5 -> val 0, depend 0.
REQ-038 Issue slot0 rd=5 rob=3; next cycle read x5 -> depend 3; commit rob=3 reg=5 val=0xDEADBEEF; next cycle -> val 0xDEADBEEF, depend 0 (same cycle: bypass only with macro).
REQ-039 Same cycle issue slot0 rd=7 rob=2, slot1 rd=7 rob=4, slot1 rs1=7 -> slot1 depend 2; next cycle dep[7]=4; commit rob=2 -> dep[7] stays 4.
REQ-040 Issue rd=0 rob=6, commit reg=0 val=0x1 -> x0 val 0, depend 0.
REQ-041 dep[3]=5, dep[9]=6, clr_in with commit reg=3 val=0x55 -> next cycle all depend 0, val[3]=0x55.
REQ-042 rdy_in low with issue and commit asserted -> table unchanged next cycle.
